fft_stage_ctrl: RTL and testbench

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

---
 rtl/fft_stage_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_ctrl.sv
// Radix-2 single-path delay-feedback FFT stage controller.
// Sequences fill / butterfly / drain phases of a 2*DELAY-beat frame and
// emits registered datapath controls one cycle after each accepted beat.
module fft_stage_ctrl #(
  parameter int unsigned DELAY = 16,
  parameter int unsigned TWW   = $clog2(2 * DELAY)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           valid_in,
  input  logic           frame_start,
  input  logic           flush,
  output logic           sr_en,
  output logic           bf_sel,
  output logic           mux_sel,
  output logic [TWW-1:0] tw_idx,
  output logic           mul_en,
  output logic           valid_out,
  output logic           frame_done,
  output logic           frame_err,
  output logic           busy
);

  localparam int unsigned CW = $clog2(2 * DELAY);
  localparam int unsigned DW = (DELAY > 1) ? $clog2(DELAY) : 1;

  localparam logic [CW-1:0] CNT_FILL_LAST = CW'(DELAY - 1);
  localparam logic [CW-1:0] CNT_LAST      = CW'(2 * DELAY - 1);
  localparam logic [DW-1:0] DCNT_LAST     = DW'(DELAY - 1);

  typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

  // With a one-beat half frame, beat 0 is already the last fill beat.
  localparam state_t FILL_NEXT = (DELAY > 1) ? FILL : BFLY;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            pend_q, pend_d;

  logic            sr_en_d, bf_sel_d, mux_sel_d, mul_en_d;
  logic            valid_out_d, frame_done_d, frame_err_d, busy_d;
  logic [TWW-1:0]  tw_idx_d;
  logic            start;
  logic            drain_beat;

  assign start = valid_in && frame_start;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      pend_q     <= 1'b0;
      sr_en      <= 1'b0;
      bf_sel     <= 1'b0;
      mux_sel    <= 1'b0;
      tw_idx     <= '0;
      mul_en     <= 1'b0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      pend_q     <= pend_d;
      sr_en      <= sr_en_d;
      bf_sel     <= bf_sel_d;
      mux_sel    <= mux_sel_d;
      tw_idx     <= tw_idx_d;
      mul_en     <= mul_en_d;
      valid_out  <= valid_out_d;
      frame_done <= frame_done_d;
      frame_err  <= frame_err_d;
      busy       <= busy_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dcnt_d       = dcnt_q;
    pend_d       = pend_q;
    sr_en_d      = 1'b0;
    bf_sel_d     = 1'b0;
    mux_sel_d    = 1'b0;
    tw_idx_d     = '0;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    drain_beat   = 1'b0;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      dcnt_d  = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FILL_NEXT;
            cnt_d   = CW'(1);
            dcnt_d  = '0;
            pend_d  = 1'b0;
            sr_en_d = 1'b1;
          end
        end

        FILL, BFLY: begin
          if (valid_in && frame_start) begin
            // Unexpected frame start: drop the current frame and restart.
            state_d     = FILL_NEXT;
            cnt_d       = CW'(1);
            dcnt_d      = '0;
            pend_d      = 1'b0;
            sr_en_d     = 1'b1;
            frame_err_d = 1'b1;
          end else if (valid_in) begin
            sr_en_d = 1'b1;
            if (state_q == FILL) begin
              drain_beat = pend_q;
              cnt_d      = cnt_q + CW'(1);
              if (cnt_q == CNT_FILL_LAST) state_d = BFLY;
            end else begin
              bf_sel_d    = 1'b1;
              valid_out_d = 1'b1;
              tw_idx_d    = TWW'(cnt_q) - TWW'(DELAY);
              if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                dcnt_d  = '0;
                state_d = DRAIN;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
        end

        DRAIN: begin
          drain_beat = 1'b1;
          if (dcnt_q == '0 && start) begin
            // Back-to-back frame: its fill beats carry out the pending drain.
            state_d = FILL_NEXT;
            cnt_d   = CW'(1);
            pend_d  = 1'b1;
            sr_en_d = 1'b1;
          end else begin
            frame_err_d = start;
            if (dcnt_q == DCNT_LAST) state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase

      // Emit one delayed difference beat from the lower half of the frame.
      if (drain_beat) begin
        valid_out_d = 1'b1;
        mux_sel_d   = 1'b1;
        tw_idx_d    = TWW'(DELAY) + TWW'(dcnt_q);
        if (dcnt_q == DCNT_LAST) begin
          frame_done_d = 1'b1;
          dcnt_d       = '0;
          pend_d       = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
    end

    mul_en_d = valid_out_d;
    busy_d   = !flush && ((state_d != IDLE) || (state_q != IDLE));
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl with DELAY=16.
module tb_fft_stage_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       valid_in;
  logic       frame_start;
  logic       flush;
  logic       sr_en;
  logic       bf_sel;
  logic       mux_sel;
  logic [4:0] tw_idx;
  logic       mul_en;
  logic       valid_out;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  // Packed view: {sr,bf,valid,mul,mux,done,err,tw[4:0]}
  localparam logic [11:0] ERR = 12'h020;

  fft_stage_ctrl #(.DELAY(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .valid_in    (valid_in),
    .frame_start (frame_start),
    .flush       (flush),
    .sr_en       (sr_en),
    .bf_sel      (bf_sel),
    .mux_sel     (mux_sel),
    .tw_idx      (tw_idx),
    .mul_en      (mul_en),
    .valid_out   (valid_out),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] observed();
    return {sr_en, bf_sel, valid_out, mul_en, mux_sel, frame_done, frame_err, tw_idx};
  endfunction

  // Expected controls k cycles after beat 0 of a clean single frame.
  function automatic logic [11:0] es(int k);
    logic [11:0] e;
    e = '0;
    if (k >= 1 && k <= 16)
      e = 12'h800;
    else if (k >= 17 && k <= 32)
      e = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'(k - 17)};
    else if (k >= 33 && k <= 48)
      e = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, (k == 48), 1'b0, 5'(k - 17)};
    return e;
  endfunction

  // Stimulus {valid_in, frame_start} for scenario sid in cycle c.
  function automatic logic [1:0] scen_in(int sid, int c);
    logic v, fs;
    v = 1'b0; fs = 1'b0;
    case (sid)
      0: begin v = (c < 32); fs = (c == 0); end
      1: begin v = (c < 64); fs = (c == 0 || c == 32); end
      2: begin v = (c <= 20) || (c >= 24 && c <= 34); fs = (c == 0); end
      3: begin v = (c < 42); fs = (c == 0 || c == 10); end
      default: begin
        v  = (c <= 32) || (c == 40) || (c >= 45 && c < 56);
        fs = (c == 0 || c == 40);
      end
    endcase
    return {v, fs};
  endfunction

  // Expected packed controls in cycle k of scenario sid.
  function automatic logic [11:0] scen_exp(int sid, int k);
    case (sid)
      0: return es(k);
      1: return es(k) | es(k - 32);
      2: return (k <= 21) ? es(k) : ((k <= 24) ? 12'h000 : es(k - 3));
      3: return (k <= 10) ? es(k) : (es(k - 10) | ((k == 11) ? ERR : 12'h000));
      default: return es(k) | ((k == 41) ? ERR : 12'h000);
    endcase
  endfunction

  function automatic int busy_end(int sid);
    case (sid)
      0: return 48;
      1: return 80;
      2: return 51;
      3: return 58;
      default: return 48;
    endcase
  endfunction

  task automatic chk(input string tag, input int k, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic chk_busy(input string tag, input int k, input logic exp);
    n_vec++;
    assert (busy === exp)
    else begin
      n_miss++;
      $error("FAIL %s_busy k=%0d observed=%b expected=%b", tag, k, busy, exp);
    end
  endtask

  // One clock with the given inputs; sample just after the edge.
  task automatic cyc(input logic v, input logic fs, input logic fl);
    valid_in    = v;
    frame_start = fs;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic run_scen(input int sid, input string tag, input int n);
    logic [1:0] s;
    for (int c = 0; c < n; c++) begin
      s = scen_in(sid, c);
      cyc(s[1], s[0], 1'b0);
      chk(tag, c + 1, observed(), scen_exp(sid, c + 1));
      chk_busy(tag, c + 1, (c + 1 >= 1) && (c + 1 <= busy_end(sid)));
    end
  endtask

  task automatic idle_zero(input string tag, input int n, input logic v);
    for (int c = 0; c < n; c++) begin
      cyc(v, 1'b0, 1'b0);
      chk(tag, c, observed(), 12'h000);
      chk_busy(tag, c, 1'b0);
    end
  endtask

  initial begin
    rstn        = 1'b0;
    valid_in    = 1'b0;
    frame_start = 1'b0;
    flush       = 1'b0;
    #12;
    chk("reset", 0, observed(), 12'h000);
    chk_busy("reset", 0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Stray valid without frame_start is ignored in IDLE.
    idle_zero("idle_ign", 3, 1'b1);

    run_scen(0, "single", 53);
    run_scen(1, "b2b", 85);
    run_scen(2, "stall", 56);
    run_scen(3, "restart", 64);
    run_scen(4, "drain_fs", 60);

    // Asynchronous reset mid-frame.
    run_scen(0, "pre_rst", 21);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst", 0, observed(), 12'h000);
    chk_busy("async_rst", 0, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle_zero("post_rst", 3, 1'b1);
    run_scen(0, "after_rst", 53);

    // Flush mid-frame, applied together with beat 20.
    run_scen(0, "pre_flush", 20);
    cyc(1'b1, 1'b0, 1'b1);
    chk("flush", 0, observed(), 12'h000);
    chk_busy("flush", 0, 1'b0);
    idle_zero("post_flush", 3, 1'b1);
    run_scen(0, "after_flush", 53);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
